// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle fetch/decode/exec/commit sequencer owning the PC and instruction register
// Define MISALIGN_TRAP_EN to redirect targets with bit1 set to TRAP_VEC with a trap strobe.
module pc_seq_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  input  logic            Branch,
  input  logic            Jal,
  input  logic            Jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic [3:0]      nzcv,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            exec_en,
  output logic            retire,
  output logic            Btaken,
  output logic [31:0]     instret,
  output logic            trap
);
  typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_COMMIT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, npc_q, npc_d, raw_pc, tgt_pc;
  logic [31:0] ir_q, ir_d, instret_q, instret_d;
  logic btaken_q, btaken_d, cond, taken, mis, exec_done;
  // nzcv = {N,Z,C,V}; C=1 means no borrow
  always_comb begin
    cond = funct3 == 3'b000 ? nzcv[2] :
           funct3 == 3'b001 ? !nzcv[2] :
           funct3 == 3'b100 ? nzcv[3] != nzcv[0] :
           funct3 == 3'b101 ? nzcv[3] == nzcv[0] :
           funct3 == 3'b110 ? !nzcv[1] :
           funct3 == 3'b111 ? nzcv[1] : 1'b0;
  end
  assign taken = Jal | Jalr | (Branch & cond);
  assign raw_pc = Jal ? pc_q + imm : Jalr ? alu_result & ~XLEN'(1) : taken ? pc_q + imm : pc_plus4;
`ifdef MISALIGN_TRAP_EN
  logic trap_q;
  assign mis = raw_pc[1];
  assign tgt_pc = mis ? TRAP_VEC : raw_pc;
  assign trap = state_q == S_COMMIT && trap_q;
  always_ff @(posedge clk) trap_q <= !reset_n ? 1'b0 : exec_done ? mis : trap_q;
`else
  assign mis = 1'b0;
  assign tgt_pc = raw_pc & ~XLEN'(3);
  assign trap = 1'b0;
`endif
  assign exec_done = state_q == S_EXEC && !stall;
  always_comb begin
    state_d = state_q == S_RESET  ? S_FETCH :
              state_q == S_FETCH  ? (imem_ack ? S_DECODE : S_FETCH) :
              state_q == S_DECODE ? S_EXEC :
              state_q == S_EXEC   ? (stall ? S_EXEC : S_COMMIT) : S_FETCH;
    ir_d = state_q == S_FETCH && imem_ack ? imem_rdata : ir_q;
    npc_d = exec_done ? tgt_pc : npc_q;
    btaken_d = exec_done ? taken | mis : btaken_q;
    pc_d = state_q == S_COMMIT ? npc_q : pc_q;
    instret_d = instret_q + 32'(state_q == S_COMMIT);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      pc_q <= RESET_PC;
      npc_q <= RESET_PC;
      ir_q <= '0;
      btaken_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      npc_q <= npc_d;
      ir_q <= ir_d;
      btaken_q <= btaken_d;
      instret_q <= instret_d;
    end
  end
  assign imem_req = state_q == S_FETCH;
  assign imem_addr = pc_q;
  assign exec_en = state_q == S_EXEC;
  assign retire = state_q == S_COMMIT;
  assign pc = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign ir = ir_q;
  assign Btaken = btaken_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;
  logic clk = 0, reset_n = 0, imem_ack = 0, Branch = 0, Jal = 0, Jalr = 0, stall = 0;
  logic [31:0] imem_rdata = 0, imm = 0, alu_result = 0;
  logic [2:0] funct3 = 0;
  logic [3:0] nzcv = 0;
  logic imem_req, exec_en, retire, Btaken, trap;
  logic [31:0] imem_addr, ir, pc, pc_plus4, instret;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] cur_pc = 0, exp_ret = 0;
  pc_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .Branch(Branch), .Jal(Jal),
    .Jalr(Jalr), .funct3(funct3), .imm(imm), .alu_result(alu_result), .nzcv(nzcv),
    .stall(stall), .pc(pc), .pc_plus4(pc_plus4), .exec_en(exec_en), .retire(retire),
    .Btaken(Btaken), .instret(instret), .trap(trap)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic dec(input logic br, input logic j, input logic jr, input logic [2:0] f3,
                     input logic [31:0] im, input logic [31:0] al);
    Branch = br; Jal = j; Jalr = jr; funct3 = f3; imm = im; alu_result = al;
  endtask
  // entered at a negedge while in FETCH; leaves at the negedge of the next FETCH
  task automatic step(input logic [31:0] rd, input int wait_n, input int stall_n, input logic [3:0] nz,
                      input logic [31:0] exp_pc, input logic exp_bt, input logic exp_tr);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, cur_pc);
    chk("pc_plus4", pc_plus4, cur_pc + 4);
    imem_ack = 0; imem_rdata = rd; nzcv = nz;
    repeat (wait_n) begin
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, cur_pc);
      chk("wait_exec", exec_en, 0);
    end
    imem_ack = 1;
    @(negedge clk);
    imem_rdata = ~rd;
    chk("dec_ir", ir, rd);
    chk("dec_req", imem_req, 0);
    chk("dec_exec", exec_en, 0);
    @(negedge clk);
    chk("exec_en", exec_en, 1);
    chk("exec_retire", retire, 0);
    if (stall_n > 0) begin
      stall = 1; nzcv = nz ^ 4'b0101;
      repeat (stall_n) begin
        @(negedge clk);
        chk("stall_exec", exec_en, 1);
        chk("stall_retire", retire, 0);
      end
      stall = 0; nzcv = nz;
    end
    @(negedge clk);
    exp_ret++;
    chk("commit_retire", retire, 1);
    chk("commit_exec", exec_en, 0);
    chk("commit_bt", Btaken, exp_bt);
    chk("commit_trap", trap, exp_tr);
    chk("commit_pc_old", pc, cur_pc);
    chk("commit_ir", ir, rd);
    @(negedge clk);
    chk("next_pc", pc, exp_pc);
    chk("next_retire", retire, 0);
    chk("next_trap", trap, 0);
    chk("instret", instret, exp_ret);
    cur_pc = exp_pc;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_bt", Btaken, 0);
    chk("rst_instret", instret, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_retire", retire, 0);
    chk("rst_trap", trap, 0);
    reset_n = 1;
    @(negedge clk);
    step(32'h0000_0013, 0, 0, 4'b0000, 32'h04, 0, 0);
    step(32'h0000_0093, 0, 0, 4'b0000, 32'h08, 0, 0);
    step(32'h0000_0113, 0, 0, 4'b0000, 32'h0C, 0, 0);
    step(32'h0000_0193, 0, 0, 4'b0000, 32'h10, 0, 0);
    dec(1, 0, 0, 3'b000, 32'h20, 0);       step(32'hA, 0, 0, 4'b0100, 32'h30, 1, 0);
    dec(1, 0, 0, 3'b000, 32'h20, 0);       step(32'hB, 0, 0, 4'b0000, 32'h34, 0, 0);
    dec(1, 0, 0, 3'b100, 32'h10, 0);       step(32'hC, 0, 0, 4'b1000, 32'h44, 1, 0);
    dec(1, 0, 0, 3'b110, 32'h10, 0);       step(32'hD, 0, 0, 4'b0010, 32'h48, 0, 0);
    dec(1, 0, 0, 3'b010, 32'h10, 0);       step(32'hE, 0, 0, 4'b1111, 32'h4C, 0, 0);
    dec(1, 0, 0, 3'b001, 32'hFFFF_FFF4, 0); step(32'hF, 0, 0, 4'b0000, 32'h40, 1, 0);
    dec(0, 1, 1, 3'b000, 32'h8, 32'h101);  step(32'h10, 0, 0, 4'b0000, 32'h48, 1, 0);
    dec(0, 0, 1, 3'b000, 32'h8, 32'h101);  step(32'h11, 0, 0, 4'b0000, 32'h100, 1, 0);
    dec(1, 0, 0, 3'b101, 32'h20, 0);       step(32'h12, 3, 2, 4'b1001, 32'h120, 1, 0);
    dec(1, 0, 0, 3'b111, 32'h10, 0);       step(32'h13, 0, 0, 4'b0010, 32'h130, 1, 0);
    dec(1, 0, 0, 3'b111, 32'h10, 0);       step(32'h14, 0, 0, 4'b0000, 32'h134, 0, 0);
    dec(0, 1, 0, 3'b000, 32'hECE, 0);
`ifdef MISALIGN_TRAP_EN
    step(32'h15, 0, 0, 4'b0000, 32'h100, 1, 1);
`else
    step(32'h15, 0, 0, 4'b0000, 32'h1000, 1, 0);
`endif
    dec(0, 0, 1, 3'b000, 0, 32'hFFFF_FFF9); step(32'h16, 0, 0, 4'b0000, 32'hFFFF_FFF8, 1, 0);
    dec(0, 1, 0, 3'b000, 32'h8, 0);         step(32'h17, 0, 0, 4'b0000, 32'h0, 1, 0);
    dec(1, 0, 1, 3'b000, 32'h20, 32'h200);  step(32'h18, 0, 0, 4'b0100, 32'h200, 1, 0);
    dec(1, 1, 0, 3'b000, 32'h40, 0);
    imem_ack = 1; imem_rdata = 32'h19;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_exec", exec_en, 1);
    reset_n = 0;
    @(negedge clk);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_instret", instret, 0);
    chk("mid_rst_retire", retire, 0);
    chk("mid_rst_exec", exec_en, 0);
    chk("mid_rst_bt", Btaken, 0);
    chk("mid_rst_ir", ir, 0);
    reset_n = 1;
    dec(0, 0, 0, 3'b000, 0, 0);
    @(negedge clk);
    cur_pc = 0; exp_ret = 0;
    step(32'h1A, 0, 0, 4'b0000, 32'h4, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Multi-cycle fetch/execute sequencer for the single-cycle-derived core. It owns the PC register, drives the instruction-memory request handshake and latches the instruction. It steps the datapath through DECODE/EXEC/COMMIT and resolves Branch/Jal/Jalr into the next PC by sampling the ALU nzcv flags at the end of EXEC. It sits between instruction memory, the decoder and the ALU/flag output.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, redirect target on misaligned target (MISALIGN_TRAP_EN only)

Ports:
clk  input  1  core clock, rising edge
reset_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  XLEN  fetch address (= pc)
imem_ack  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction
ir  output  32  latched instruction register
Branch  input  1  decoded conditional branch
Jal  input  1  decoded JAL
Jalr  input  1  decoded JALR
funct3  input  3  branch condition select
imm  input  XLEN  sign-extended immediate
alu_result  input  XLEN  ALU output (JALR target rs1+imm)
nzcv  input  4  ALU flags {N,Z,C,V}, valid in EXEC
stall  input  1  extends EXEC (multi-cycle op / data memory busy)
pc  output  XLEN  current PC
pc_plus4  output  XLEN  pc+4 (link value)
exec_en  output  1  high in every EXEC cycle
retire  output  1  one-cycle strobe in COMMIT
Btaken  output  1  registered resolution of last branch/jump
instret  output  32  retired-instruction counter
trap  output  1  one-cycle strobe on misaligned redirect (MISALIGN_TRAP_EN only, else tied 0)

Behaviour:
- Reset (reset_n=0 at posedge): state=RESET, pc=RESET_PC, ir=0, Btaken=0, instret=0; all Moore outputs (imem_req, exec_en, retire, trap) are 0 in RESET. Reset wins over every other event in any state.
- States: RESET -> FETCH (unconditional, next cycle).
- FETCH: imem_req=1, imem_addr=pc, held stable. On imem_ack=1: ir<=imem_rdata, go to DECODE. A same-cycle ack is legal. imem_ack outside FETCH is ignored.
- DECODE: one cycle for the decoder to settle, then go to EXEC.
- EXEC: exec_en=1. While stall=1, remain in EXEC with nothing latched. When stall=0: sample nzcv, latch next_pc and Btaken, go to COMMIT.
- COMMIT: pc<=next_pc, retire=1, instret<=instret+1 (wraps 32'hFFFF_FFFF -> 0), go to FETCH.
- Minimum 4 cycles per instruction (ack same cycle, no stall).
- Condition, funct3 vs nzcv:
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: N!=V
  - 101 BGE: N==V
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010/011: not taken
- C=1 means no borrow (rs1>=rs2 unsigned).
- next_pc priority:
  1. Jal: pc+imm, Btaken=1
  2. Jalr: alu_result with bit0 cleared, Btaken=1
  3. Branch and condition true: pc+imm, Btaken=1
  4. Otherwise: pc+4, Btaken=0
- Multiple decode bits set resolve by this priority.
- All PC arithmetic is modulo 2^XLEN (wraps silently).
- pc_plus4 is combinational pc+4.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: if the selected next_pc has bit1 set, COMMIT loads TRAP_VEC instead, pulses trap=1 with retire, and Btaken=1.
- Undefined: next_pc[1:0] is forced to 2'b00, the trap port is tied 0 and the TRAP_VEC parameter is unused.

Test Plan:
- Reset release, imem_ack=1 immediately, all decode inputs 0 -> imem_addr=0, retire pulses every 4 cycles, pc 0->4->8, instret=3 after 3 retires.
- Branch=1, funct3=000, nzcv=4'b0100, pc=0x10, imm=0x20 -> pc=0x30, Btaken=1; repeat with nzcv=0 -> pc=0x14, Btaken=0.
- funct3=100 with nzcv=4'b1000 -> taken; funct3=110 with nzcv=4'b0010 -> not taken; funct3=010 -> pc+4.
- Jalr=1 and Jal=1 together, alu_result=0x101, pc=0x40, imm=0x8 -> Jal wins, pc=0x48; Jalr alone -> pc=0x100.
- imem_ack withheld 3 cycles, then stall=1 for 2 EXEC cycles -> imem_req/imem_addr stable throughout, exec_en high 3 cycles, single retire, nzcv changes during stall ignored.
- reset_n=0 asserted in EXEC -> next cycle pc=RESET_PC, instret=0, no retire; with MISALIGN_TRAP_EN, Jal target 0x1002 -> pc=0x100, trap=1 for one cycle.
